// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR sequencing controller.
package fir_pkg;
  localparam int TAPS       = 32;
  localparam int TAP_W      = 5;
  localparam int ADDR_W     = 14;
  localparam int OUT_CYCLES = TAPS + 4;

  localparam logic [TAP_W:0] K_LAST = (TAP_W+1)'(TAPS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, SHIFT, MAC, DRAIN, WRITE, DONE
  } state_t;
endpackage

// File: rtl/fir_ctrl.sv
// Sequencer for the 32-tap FIR: clears the sample shift register, then per output
// fetches a sample, walks all taps into the MAC and writes the result to output RAM.
module fir_ctrl
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ile_probek,
  output logic [ADDR_W-1:0] ile_probek_q,
  output logic              busy,
  output logic              done,
  output logic              ram_in_re,
  output logic [ADDR_W-1:0] ram_in_addr,
  output logic              reset_shift,
  output logic              nowa_shift,
  output logic [TAP_W-1:0]  adres,
  output logic [TAP_W-1:0]  coef_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              ram_out_we,
  output logic [ADDR_W:0]   ram_out_addr
);

  state_t            state_q;
  logic [ADDR_W:0]   n_q;
  logic [TAP_W:0]    k_q;

  logic [ADDR_W:0]   n_last_d;
  logic [ADDR_W:0]   n_inc_d;
  logic [TAP_W:0]    k_inc_d;

  // Last output index is N+TAPS-2; one extra bit keeps it from wrapping.
  always_comb begin
    n_last_d = {1'b0, ile_probek_q} + (ADDR_W+1)'(TAPS - 2);
    n_inc_d  = n_q + (ADDR_W+1)'(1);
    k_inc_d  = k_q + (TAP_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      k_q          <= '0;
      ile_probek_q <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ram_in_re    <= 1'b0;
      ram_in_addr  <= '0;
      reset_shift  <= 1'b0;
      nowa_shift   <= 1'b0;
      adres        <= '0;
      coef_addr    <= '0;
      mac_clr      <= 1'b0;
      mac_en       <= 1'b0;
      ram_out_we   <= 1'b0;
      ram_out_addr <= '0;
    end else begin
      done        <= 1'b0;
      reset_shift <= 1'b0;
      nowa_shift  <= 1'b0;
      ram_in_re   <= 1'b0;
      ram_out_we  <= 1'b0;
      // Tap data lags the tap address by one cycle, so the MAC strobes follow
      // the walk one stage late; the final tap lands in DRAIN.
      mac_en      <= (state_q == MAC);
      mac_clr     <= (state_q == MAC) && (k_q == '0);

      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (ile_probek != '0) begin
              ile_probek_q <= ile_probek;
              n_q          <= '0;
              reset_shift  <= 1'b1;
              state_q      <= CLEAR;
            end else begin
              done    <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CLEAR: begin
          ram_in_addr <= n_q[ADDR_W-1:0];
          ram_in_re   <= (n_q < {1'b0, ile_probek_q});
          state_q     <= FETCH;
        end
        FETCH: begin
          nowa_shift <= 1'b1;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          k_q       <= '0;
          adres     <= '0;
          coef_addr <= '0;
          state_q   <= MAC;
        end
        MAC: begin
          if (k_q == K_LAST) begin
            state_q <= DRAIN;
          end else begin
            k_q       <= k_inc_d;
            adres     <= k_inc_d[TAP_W-1:0];
            coef_addr <= k_inc_d[TAP_W-1:0];
          end
        end
        DRAIN: begin
          ram_out_we   <= 1'b1;
          ram_out_addr <= n_q;
          state_q      <= WRITE;
        end
        WRITE: begin
          if (n_q == n_last_d) begin
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            // Past the last input sample the shift register zero-fills, so no read.
            n_q         <= n_inc_d;
            ram_in_addr <= n_inc_d[ADDR_W-1:0];
            ram_in_re   <= (n_inc_d < {1'b0, ile_probek_q});
            state_q     <= FETCH;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl: traces each run and compares it against a
// cycle schedule derived from the per-output phase arithmetic.
module tb_fir_ctrl;
  import fir_pkg::*;

  localparam int PER = TAPS + 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] ile_probek = '0;
  logic [ADDR_W-1:0] ile_probek_q;
  logic              busy, done, ram_in_re, reset_shift, nowa_shift;
  logic              mac_clr, mac_en, ram_out_we;
  logic [ADDR_W-1:0] ram_in_addr;
  logic [TAP_W-1:0]  adres, coef_addr;
  logic [ADDR_W:0]   ram_out_addr;

  fir_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .ile_probek(ile_probek),
    .ile_probek_q(ile_probek_q), .busy(busy), .done(done),
    .ram_in_re(ram_in_re), .ram_in_addr(ram_in_addr),
    .reset_shift(reset_shift), .nowa_shift(nowa_shift),
    .adres(adres), .coef_addr(coef_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .ram_out_we(ram_out_we), .ram_out_addr(ram_out_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              busy, done, re, rs, ns, clr, en, we;
    logic [ADDR_W-1:0] in_addr;
    logic [TAP_W-1:0]  adr, coef;
    logic [ADDR_W:0]   out_addr;
    logic [ADDR_W-1:0] nq;
  } smp_t;

  typedef struct {
    int n; int writes; int nowa; int re; int done_at;
  } vec_t;

  smp_t tr[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic smp_t cap();
    smp_t s;
    s.busy = busy; s.done = done; s.re = ram_in_re; s.rs = reset_shift;
    s.ns = nowa_shift; s.clr = mac_clr; s.en = mac_en; s.we = ram_out_we;
    s.in_addr = ram_in_addr; s.adr = adres; s.coef = coef_addr;
    s.out_addr = ram_out_addr; s.nq = ile_probek_q;
    return s;
  endfunction

  function automatic logic [7:0] strb(input smp_t s);
    return {s.busy, s.done, s.re, s.rs, s.ns, s.clr, s.en, s.we};
  endfunction

  // Expected behaviour at trace index t (t=0 is the cycle after start is accepted).
  task automatic model(input int t, input int n, output smp_t m, output bit mac_c);
    int L, i, u, j;
    m = '0; mac_c = 1'b0;
    L = (n == 0) ? 0 : 1 + (n + TAPS - 1) * PER;
    m.busy = (t <= L);
    if (n == 0) begin m.done = (t == 0); return; end
    if (t == 0) m.rs = 1'b1;
    else if (t == L) m.done = 1'b1;
    else if (t < L) begin
      i = (t - 1) / PER; u = (t - 1) % PER;
      if (u == 0) begin m.re = (i < n); m.in_addr = ADDR_W'(i); end
      else if (u == 1) m.ns = 1'b1;
      else if (u < 2 + TAPS) begin
        j = u - 2; mac_c = 1'b1; m.adr = TAP_W'(j);
        m.en = (j >= 1); m.clr = (j == 1);
      end
      else if (u == 2 + TAPS) m.en = 1'b1;
      else begin m.we = 1'b1; m.out_addr = (ADDR_W+1)'(i); end
    end
  endtask

  // Starts a run with N=n and records every cycle until done (bounded).
  task automatic run(input int n, input bit poke, output bit busy_after);
    int budget;
    smp_t s;
    budget = 2 + (n + TAPS - 1) * PER + 40;
    tr.delete();
    start = 1'b1; ile_probek = ADDR_W'(n);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < budget; t++) begin
      s = cap();
      tr.push_back(s);
      if (poke && t == 100) begin start = 1'b1; ile_probek = ADDR_W'(9); end
      if (poke && t == 101) start = 1'b0;
      @(negedge clk);
      if (s.done) break;
    end
    busy_after = busy;
  endtask

  task automatic verify(input string tag, input int n, input int wr, input int nw,
                        input int rr, input int dat, input bit busy_after);
    int wc = 0, nc = 0, rc = 0, di = -1, sbad = 0, abad = 0, mbad = 0, ibad = 0;
    int ec, cc;
    smp_t a, m;
    bit mac_c;
    for (int t = 0; t < tr.size(); t++) begin
      a = tr[t];
      model(t, n, m, mac_c);
      if (a.we) wc++;
      if (a.ns) nc++;
      if (a.re) rc++;
      if (a.done && di < 0) di = t;
      if (strb(a) !== strb(m)) sbad++;
      if (m.re && a.in_addr !== m.in_addr) abad++;
      if (m.we && a.out_addr !== m.out_addr) abad++;
      if (mac_c && (a.adr !== m.adr || a.coef !== m.adr)) abad++;
      if (n != 0 && a.nq !== ADDR_W'(n)) ibad++;
      if (a.ns) begin
        ec = 0; cc = 0;
        if (t + TAPS + 2 >= tr.size()) mbad++;
        else begin
          for (int d = 1; d <= TAPS + 2; d++) begin
            if (tr[t+d].en) ec++;
            if (tr[t+d].clr) cc++;
          end
          if (ec != TAPS || cc != 1 || !tr[t+2].clr) mbad++;
        end
      end
    end
    chk({tag, " done_at"}, di, dat);
    chk({tag, " writes"}, wc, wr);
    chk({tag, " nowa_cnt"}, nc, nw);
    chk({tag, " re_cnt"}, rc, rr);
    chk({tag, " strobe_sched_errs"}, sbad, 0);
    chk({tag, " addr_errs"}, abad, 0);
    chk({tag, " mac_per_out_errs"}, mbad, 0);
    chk({tag, " ile_q_unstable"}, ibad, 0);
    chk({tag, " busy_after_done"}, busy_after, 0);
  endtask

  initial begin
    vec_t vt[4];
    bit   ba;
    int   n, act;

    vt[0] = '{1, 32, 32, 1, 1153};
    vt[1] = '{3, 34, 34, 3, 1225};
    vt[2] = '{0,  0,  0, 0,    0};
    vt[3] = '{7, 38, 38, 7, 1369};

    repeat (3) @(negedge clk);
    chk("reset_state", {strb(cap()), ram_in_addr, adres, coef_addr, ram_out_addr, ile_probek_q}, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[v]) begin
      run(vt[v].n, 1'b0, ba);
      verify($sformatf("vec%0d", v), vt[v].n, vt[v].writes, vt[v].nowa, vt[v].re, vt[v].done_at, ba);
    end

    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(2, 6));
      run(n, 1'b0, ba);
      verify($sformatf("rnd%0d_n%0d", r, n), n, n + TAPS - 1, n + TAPS - 1, n,
             1 + (n + TAPS - 1) * PER, ba);
    end

    // Restart attempt and count change mid-run must be ignored.
    run(5, 1'b1, ba);
    verify("restart_ign", 5, 36, 36, 5, 1297, ba);

    // Reset during MAC of output 2 aborts the run.
    tr.delete();
    start = 1'b1; ile_probek = ADDR_W'(5);
    @(negedge clk);
    start = 1'b0;
    repeat (85) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {strb(cap()), ile_probek_q}, 0);
    act = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || ram_out_we || ram_in_re || nowa_shift || mac_en) act++;
    end
    chk("abort_quiet", act, 0);
    run(2, 1'b0, ba);
    verify("after_abort", 2, 33, 33, 2, 1189, ba);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
